// File: rtl/dma_job_sched.sv
// dma_job_sched
// Descriptor queue plus single-job tracker in front of a DMA engine. Descriptors
// {read address, write address, size} are queued in a FIFO. When the engine is
// idle, the head descriptor is popped into the output registers. A one-cycle
// dma_go pulse then starts the transfer, and the scheduler waits for the engine's
// done level before it counts the job as complete.
//
// Optional feature: define DMA_JOB_SCHED_WATCHDOG_EN to compile in a watchdog
// on the WAIT state. It sets the sticky err flag and parks the FSM in HALT until
// abort. Without the macro, err is tied low and WAIT may last indefinitely.
//
// Ports
//   clk           sole clock, all state on rising edge
//   rst           asynchronous active-low reset
//   desc_valid    descriptor offered
//   desc_ready    queue can accept (not full, not halted)
//   desc_rd_addr  source cache-line address
//   desc_wr_addr  destination cache-line address
//   desc_size     transfer length in cache lines
//   abort         flush queue and drop the current job
//   dma_go        one-cycle start pulse to the DMA engine
//   dma_rd_addr   read address of the current job, held until completion
//   dma_wr_addr   write address of the current job, held until completion
//   dma_size      size of the current job, held until completion
//   dma_done      DMA write-side done level
//   busy          job outstanding or queue non-empty
//   jobs_done     completed-job count (wraps)
//   err           sticky watchdog timeout flag
module dma_job_sched #(
    parameter int ADDR_WIDTH     = 42,
    parameter int SIZE_WIDTH     = ADDR_WIDTH + 1,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [ADDR_WIDTH-1:0] desc_rd_addr,
    input  logic [ADDR_WIDTH-1:0] desc_wr_addr,
    input  logic [SIZE_WIDTH-1:0] desc_size,
    input  logic                  abort,
    output logic                  dma_go,
    output logic [ADDR_WIDTH-1:0] dma_rd_addr,
    output logic [ADDR_WIDTH-1:0] dma_wr_addr,
    output logic [SIZE_WIDTH-1:0] dma_size,
    input  logic                  dma_done,
    output logic                  busy,
    output logic [31:0]           jobs_done,
    output logic                  err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, HALT} state_t;

    state_t state, next_state;

    logic [ADDR_WIDTH-1:0] rd_mem   [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_mem   [DEPTH];
    logic [SIZE_WIDTH-1:0] size_mem [DEPTH];
    logic [PTR_W-1:0]      head, tail;
    logic [PTR_W:0]        count;

    logic empty, full, push, pop, head_zero, count_job, wd_expire;

    assign empty     = (count == '0);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign push      = desc_valid && desc_ready && !abort;
    assign pop       = (state == IDLE) && !empty && !abort;
    assign head_zero = (size_mem[head] == '0);

    // A job completes on done in WAIT, or instantly when a size-0 descriptor is popped.
    assign count_job = !abort && (((state == WAIT) && dma_done) || (pop && head_zero));

    // Queue storage; the pointers alone define validity, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail]   <= desc_rd_addr;
            wr_mem[tail]   <= desc_wr_addr;
            size_mem[tail] <= desc_size;
        end
    end

    // Queue pointers; DEPTH is a power of two so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (abort) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Size-0 descriptors leave the previous job's registers untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_rd_addr <= '0;
            dma_wr_addr <= '0;
            dma_size    <= '0;
        end else if (pop && !head_zero) begin
            dma_rd_addr <= rd_mem[head];
            dma_wr_addr <= wr_mem[head];
            dma_size    <= size_mem[head];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jobs_done <= '0;
        end else if (count_job) begin
            jobs_done <= jobs_done + 32'd1;
        end
    end

`ifdef DMA_JOB_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    // Fires at the end of the TIMEOUT_CYCLES-th consecutive WAIT cycle without done.
    assign wd_expire = (state == WAIT) && !dma_done && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state != WAIT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (wd_expire && !abort) begin
            err <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ARM exists so a done level still high from the previous job is ignored.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (!empty && !head_zero) next_state = ISSUE;
                ISSUE:   next_state = ARM;
                ARM:     next_state = WAIT;
                WAIT: begin
                    if (dma_done)       next_state = IDLE;
                    else if (wd_expire) next_state = HALT;
                end
                HALT:    next_state = HALT;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        dma_go     = (state == ISSUE) && !abort;
        desc_ready = !full && (state != HALT);
        busy       = (state != IDLE) || !empty;
    end

endmodule
